// File: rtl/freq_display_driver.sv
// Binary-to-BCD (double-dabble) converter and 4-digit multiplexed 7-segment driver.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module freq_display_driver #(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic        mclk,
    input  logic        rst_n,
    input  logic [11:0] freq,
    output logic [15:0] bcd,
    output logic        busy,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an
);

    localparam int unsigned PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t        state_q, state_d;
    logic [11:0]   last_q, last_d;
    logic [27:0]   sh_q, sh_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [15:0]   bcd_q, bcd_d;
    logic          busy_q, busy_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [1:0]    sel_q, sel_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic [27:0]   adj;
    logic [3:0]    nib;
    logic          blank;

    function automatic logic [6:0] seg_code(input logic [3:0] n);
        case (n)
            4'd0:    seg_code = 7'h40;
            4'd1:    seg_code = 7'h79;
            4'd2:    seg_code = 7'h24;
            4'd3:    seg_code = 7'h30;
            4'd4:    seg_code = 7'h19;
            4'd5:    seg_code = 7'h12;
            4'd6:    seg_code = 7'h02;
            4'd7:    seg_code = 7'h78;
            4'd8:    seg_code = 7'h00;
            4'd9:    seg_code = 7'h10;
            default: seg_code = 7'h7F;
        endcase
    endfunction

    always_ff @(posedge mclk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= '0;
            sh_q    <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            busy_q  <= 1'b0;
            pre_q   <= '0;
            sel_q   <= '0;
            an_q    <= '1;
            seg_q   <= '1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            busy_q  <= busy_d;
            pre_q   <= pre_d;
            sel_q   <= sel_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    // Conversion FSM: shift register holds {bcd[15:0], binary[11:0]}.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        adj     = sh_q;
        case (state_q)
            IDLE: begin
                if (freq != last_q) begin
                    sh_d    = {16'h0000, freq};
                    last_d  = freq;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                for (int unsigned i = 0; i < 4; i++) begin
                    if (adj[12 + 4*i +: 4] >= 4'd5)
                        adj[12 + 4*i +: 4] = adj[12 + 4*i +: 4] + 4'd3;
                end
                sh_d  = {adj[26:0], 1'b0};
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd11)
                    state_d = DONE;
            end
            DONE: begin
                bcd_d   = sh_q[27:12];
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_comb begin
        pre_d = pre_q + PW'(1);
        sel_d = sel_q;
        if (pre_q == PW'(REFRESH_DIV - 1)) begin
            pre_d = '0;
            sel_d = sel_q + 2'd1;
        end
        case (sel_q)
            2'd0:    nib = bcd_q[3:0];
            2'd1:    nib = bcd_q[7:4];
            2'd2:    nib = bcd_q[11:8];
            default: nib = bcd_q[15:12];
        endcase
        blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        case (sel_q)
            2'd1:    blank = (bcd_q[15:4] == 12'h000);
            2'd2:    blank = (bcd_q[15:8] == 8'h00);
            2'd3:    blank = (bcd_q[15:12] == 4'h0);
            default: blank = 1'b0;
        endcase
`endif
        an_d  = ~(4'b0001 << sel_q);
        seg_d = blank ? 7'h7F : seg_code(nib);
    end

    assign bcd  = bcd_q;
    assign busy = busy_q;
    assign an   = an_q;
    assign seg  = seg_q;
    assign dp   = 1'b1;

endmodule
